spart: RTL and testbench
========================

# spart

- Serial Port Attached to Register Transfer: the UART endpoint that sits directly downstream of the host-side driver.
- Accepts bus transactions (`iocs`, `iorw`, `ioaddr`, bidirectional `databus`) that:
  - program the baud divisor;
  - load transmit bytes;
  - read received bytes and status.
- Serialises and deserialises 8N1 frames on `txd`/`rxd`.
- Reports `rda` (received data available) and `tbr` (transmit buffer ready) back to the driver.

## Interface
Parameters:
- `DB_RESET`, 16'h028A — divisor loaded at reset: 4800 baud at 50 MHz with 16x oversampling.

Ports:
- `clk` input 1 — single clock; all state on rising edge.
- `rst` input 1 — synchronous, active-high reset.
- `iocs` input 1 — chip select; no access unless high.
- `iorw` input 1 — 1: read (SPART→driver), 0: write (driver→SPART).
- `ioaddr` input 2 — 00 TX/RX buffer, 01 status (read-only), 10 DB low, 11 DB high.
- `databus` inout 8 — shared data bus.
- `rda` output 1 — received byte waiting in RX buffer.
- `tbr` output 1 — transmitter idle, ready for a byte.
- `txd` output 1 — serial out, idle high.
- `rxd` input 1 — serial in, asynchronous.

## Operation
- **Bus drive:** SPART drives `databus` only when `iocs && iorw && ioaddr[1]==0`; otherwise `'Z`.
  - Addr 00 read returns the RX buffer.
  - Addr 01 read returns `{5'b0, ferr, tbr, rda}`.
- **Writes:** take effect on the clock edge where `iocs && !iorw`.
  - DB low/high writes update the divisor bytes. A DB-high write also reloads the baud counter.
  - A write to addr 00 with `tbr=0` is ignored.
- **Baud generator:** 16-bit down-counter, reloaded with the divisor when it reaches 0.
  - Emits a 1-cycle `tick` on the reload.
  - Tick period = divisor+1 cycles; 16 ticks = one bit.
- **TX FSM:** IDLE → START → DATA(8, LSB first) → STOP → IDLE.
  - A write at addr 00 in IDLE captures the byte and forces `tbr=0` next cycle.
  - The tick sub-counter clears on load.
  - Each bit lasts 16 ticks.
  - `tbr` returns to 1 in the cycle after STOP completes.
- **RX path:** `rxd` passes through a 2-FF synchroniser.
- **RX FSM:** IDLE → START → DATA → STOP.
  - IDLE: a synchronised low starts the tick sub-counter.
  - START: resample at tick 8. If high, treat as a glitch and return to IDLE.
  - DATA: sample every 16 ticks (mid-bit), shifting LSB first.
  - STOP: sample at mid-bit. The byte then moves to the RX buffer and `rda=1`, subject to Configuration.
- **RX read:** a read of addr 00 clears `rda` next cycle.
- **Simultaneous events:**
  - A byte completing in the same cycle as an addr-00 read: the new byte wins and `rda` stays 1.
  - A byte completing while `rda=1` (overrun): the new byte overwrites and `rda` stays 1.
- **Reset values:**
  - `txd=1`, `tbr=1`, `rda=0`, `databus='Z`
  - divisor = `DB_RESET`
  - both FSMs in IDLE, RX buffer 0, `ferr=0`
- Reset mid-frame aborts TX (line returns high next cycle) and discards the partial RX byte.

## Timing
- Register writes: visible one cycle after the write edge.
- Read data: combinational from registered state while the select is held.
- `txd` goes low the cycle after the addr-00 write edge.
- The first bit may be up to one tick period longer than 16 ticks because the baud counter free-runs. All later bits are exactly 16 ticks.
- RX latency: `rda` rises 1 cycle after the stop-bit mid-sample, plus 2 cycles of synchroniser delay relative to `rxd`.
- Divisor change mid-frame takes effect at the next reload; frame corruption is permitted.

## Configuration
- **`SPART_FRAME_ERR_EN` defined:**
  - A stop bit sampled low discards the byte; the RX buffer and `rda` are unchanged.
  - Sets `ferr` (status bit 2). A status read clears `ferr` next cycle.
- **`SPART_FRAME_ERR_EN` undefined:**
  - Bytes are accepted regardless of the stop-bit level.
  - Status bit 2 reads 0; no `ferr` flop exists.

## Test plan
- **Reset state:** assert `rst` for 2 cycles → `txd=1`, `tbr=1`, `rda=0`; status read = 8'h02; bus `'Z` when `iorw=0`.
- **TX frame:** divisor 4 (DB low 8'h04, DB high 8'h00), write 8'hA5 at addr 00 →
  - `tbr` falls next cycle;
  - `txd` shows 0,1,0,1,0,0,1,0,1,1, each bit 80 cycles (first bit ≤ 85);
  - `tbr` rises after the stop bit.
- **RX loopback:** tie `txd`→`rxd`, send 8'h3C → `rda=1`; addr-00 read returns 8'h3C; `rda=0` one cycle after the read.
- **Ignored write:** write 8'h11 then 8'h22 back-to-back while `tbr=0` → only 8'h11 is serialised.
- **Glitch rejection and overrun:**
  - A 3-tick low pulse on `rxd` → no `rda`.
  - Two frames 8'h01, 8'h02 with no read → buffer reads 8'h02.
- **Frame error (with `SPART_FRAME_ERR_EN`):**
  - A frame with stop bit 0 → `rda` stays 0, status = 8'h06.
  - A second status read → 8'h02.
  - Without the macro: `rda=1` and status bit 2 = 0.

Source files
------------

// File: rtl/spart.sv
// spart: bus-mapped 8N1 UART. Reads are combinational, writes land on the next edge, and a TX load is dropped while tbr=0.
// Build option SPART_FRAME_ERR_EN: bytes with a low stop bit are discarded and ferr (status bit 2) is set.
module spart #(
    parameter logic [15:0] DB_RESET = 16'h028A
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       iocs,
    input  logic       iorw,
    input  logic [1:0] ioaddr,
    inout  wire  [7:0] databus,
    output logic       rda,
    output logic       tbr,
    output logic       txd,
    input  logic       rxd
);

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    logic        w_wr, w_rd, w_wr_tx, w_rd_rx, w_rd_stat, w_bus_oe;
    logic [7:0]  w_rd_dat;
    logic        w_tick, w_ferr;

    logic [15:0] r_db;
    logic [15:0] r_baud_cnt;

    tx_state_t   r_tx_state, w_tx_state_nxt;
    logic [7:0]  r_tx_shift, w_tx_shift_nxt;
    logic [3:0]  r_tx_tick,  w_tx_tick_nxt;
    logic [2:0]  r_tx_bit,   w_tx_bit_nxt;
    logic        r_txd,      w_txd_nxt;
    logic        w_tx_bit_end;

    logic        r_rx_meta, r_rx_sync;
    rx_state_t   r_rx_state, w_rx_state_nxt;
    logic [7:0]  r_rx_shift, w_rx_shift_nxt;
    logic [3:0]  r_rx_tick,  w_rx_tick_nxt;
    logic [2:0]  r_rx_bit,   w_rx_bit_nxt;
    logic [7:0]  r_rx_buf;
    logic        r_rda;
    logic        w_rx_done, w_rx_accept;

    assign w_wr      = iocs && !iorw;
    assign w_rd      = iocs && iorw;
    assign w_wr_tx   = w_wr && (ioaddr == 2'b00);
    assign w_rd_rx   = w_rd && (ioaddr == 2'b00);
    assign w_rd_stat = w_rd && (ioaddr == 2'b01);
    assign w_bus_oe  = w_rd && !ioaddr[1];

    assign w_rd_dat = ioaddr[0] ? {5'b0, w_ferr, tbr, r_rda} : r_rx_buf;
    assign databus  = w_bus_oe ? w_rd_dat : 8'hzz;

    // Baud generator: tick on the reload cycle, so the tick period is divisor+1.
    assign w_tick = (r_baud_cnt == 16'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_db       <= DB_RESET;
            r_baud_cnt <= DB_RESET;
        end else begin
            if (w_wr && (ioaddr == 2'b10))
                r_db[7:0] <= databus;
            if (w_wr && (ioaddr == 2'b11)) begin
                r_db[15:8] <= databus;
                r_baud_cnt <= {databus, r_db[7:0]};
            end else if (w_tick) begin
                r_baud_cnt <= r_db;
            end else begin
                r_baud_cnt <= r_baud_cnt - 16'd1;
            end
        end
    end

    // Transmitter
    assign w_tx_bit_end = w_tick && (r_tx_tick == 4'd15);

    always_comb begin
        w_tx_state_nxt = r_tx_state;
        w_tx_shift_nxt = r_tx_shift;
        w_tx_tick_nxt  = r_tx_tick;
        w_tx_bit_nxt   = r_tx_bit;
        w_txd_nxt      = 1'b1;
        case (r_tx_state)
            TX_IDLE: begin
                if (w_wr_tx) begin
                    w_tx_state_nxt = TX_START;
                    w_tx_shift_nxt = databus;
                    w_tx_tick_nxt  = 4'd0;
                    w_tx_bit_nxt   = 3'd0;
                end
            end
            TX_START: begin
                if (w_tick)
                    w_tx_tick_nxt = r_tx_tick + 4'd1;
                if (w_tx_bit_end)
                    w_tx_state_nxt = TX_DATA;
            end
            TX_DATA: begin
                if (w_tick)
                    w_tx_tick_nxt = r_tx_tick + 4'd1;
                if (w_tx_bit_end) begin
                    w_tx_shift_nxt = {1'b0, r_tx_shift[7:1]};
                    w_tx_bit_nxt   = r_tx_bit + 3'd1;
                    if (r_tx_bit == 3'd7)
                        w_tx_state_nxt = TX_STOP;
                end
            end
            TX_STOP: begin
                if (w_tick)
                    w_tx_tick_nxt = r_tx_tick + 4'd1;
                if (w_tx_bit_end)
                    w_tx_state_nxt = TX_IDLE;
            end
            default: w_tx_state_nxt = TX_IDLE;
        endcase
        // Line level is registered from the next state so txd never glitches.
        case (w_tx_state_nxt)
            TX_START: w_txd_nxt = 1'b0;
            TX_DATA:  w_txd_nxt = w_tx_shift_nxt[0];
            default:  w_txd_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_state <= TX_IDLE;
            r_tx_shift <= 8'd0;
            r_tx_tick  <= 4'd0;
            r_tx_bit   <= 3'd0;
            r_txd      <= 1'b1;
        end else begin
            r_tx_state <= w_tx_state_nxt;
            r_tx_shift <= w_tx_shift_nxt;
            r_tx_tick  <= w_tx_tick_nxt;
            r_tx_bit   <= w_tx_bit_nxt;
            r_txd      <= w_txd_nxt;
        end
    end

    assign txd = r_txd;
    assign tbr = (r_tx_state == TX_IDLE);

    // Receiver: start is confirmed 8 ticks in, then every 16 ticks lands mid-bit.
    always_comb begin
        w_rx_state_nxt = r_rx_state;
        w_rx_shift_nxt = r_rx_shift;
        w_rx_tick_nxt  = r_rx_tick;
        w_rx_bit_nxt   = r_rx_bit;
        w_rx_done      = 1'b0;
        case (r_rx_state)
            RX_IDLE: begin
                if (!r_rx_sync) begin
                    w_rx_state_nxt = RX_START;
                    w_rx_tick_nxt  = 4'd0;
                    w_rx_bit_nxt   = 3'd0;
                end
            end
            RX_START: begin
                if (w_tick)
                    w_rx_tick_nxt = r_rx_tick + 4'd1;
                if (w_tick && (r_rx_tick == 4'd7)) begin
                    w_rx_tick_nxt  = 4'd0;
                    w_rx_state_nxt = r_rx_sync ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (w_tick)
                    w_rx_tick_nxt = r_rx_tick + 4'd1;
                if (w_tick && (r_rx_tick == 4'd15)) begin
                    w_rx_shift_nxt = {r_rx_sync, r_rx_shift[7:1]};
                    w_rx_bit_nxt   = r_rx_bit + 3'd1;
                    if (r_rx_bit == 3'd7)
                        w_rx_state_nxt = RX_STOP;
                end
            end
            RX_STOP: begin
                if (w_tick)
                    w_rx_tick_nxt = r_rx_tick + 4'd1;
                if (w_tick && (r_rx_tick == 4'd15)) begin
                    w_rx_state_nxt = RX_IDLE;
                    w_rx_done      = 1'b1;
                end
            end
            default: w_rx_state_nxt = RX_IDLE;
        endcase
    end

`ifdef SPART_FRAME_ERR_EN
    logic r_ferr;

    assign w_rx_accept = w_rx_done && r_rx_sync;
    assign w_ferr      = r_ferr;

    always_ff @(posedge clk) begin
        if (rst)
            r_ferr <= 1'b0;
        else if (w_rx_done && !r_rx_sync)
            r_ferr <= 1'b1;
        else if (w_rd_stat)
            r_ferr <= 1'b0;
    end
`else
    assign w_rx_accept = w_rx_done;
    assign w_ferr      = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_meta  <= 1'b1;
            r_rx_sync  <= 1'b1;
            r_rx_state <= RX_IDLE;
            r_rx_shift <= 8'd0;
            r_rx_tick  <= 4'd0;
            r_rx_bit   <= 3'd0;
            r_rx_buf   <= 8'd0;
            r_rda      <= 1'b0;
        end else begin
            r_rx_meta  <= rxd;
            r_rx_sync  <= r_rx_meta;
            r_rx_state <= w_rx_state_nxt;
            r_rx_shift <= w_rx_shift_nxt;
            r_rx_tick  <= w_rx_tick_nxt;
            r_rx_bit   <= w_rx_bit_nxt;
            // A completing byte beats a concurrent read and overwrites an unread one.
            if (w_rx_accept) begin
                r_rx_buf <= r_rx_shift;
                r_rda    <= 1'b1;
            end else if (w_rd_rx) begin
                r_rda <= 1'b0;
            end
        end
    end

    assign rda = r_rda;

endmodule

// File: tb/tb_spart.sv
// Bench for spart: register-level vectors, bench-side UART transmitter/receiver models, and multi-cycle corner sequences.
module tb_spart;

    logic       clk;
    logic       rst;
    logic       iocs;
    logic       iorw;
    logic [1:0] ioaddr;
    wire  [7:0] databus;
    logic       rda;
    logic       tbr;
    logic       txd;
    logic       rxd;

    logic       tb_drv;
    logic [7:0] tb_dat;
    logic       loop;
    logic       tb_rxd;

    int n_tests;
    int n_fail;

    assign databus = tb_drv ? tb_dat : 8'hzz;
    assign rxd     = loop ? txd : tb_rxd;

    spart dut (
        .clk     (clk),
        .rst     (rst),
        .iocs    (iocs),
        .iorw    (iorw),
        .ioaddr  (ioaddr),
        .databus (databus),
        .rda     (rda),
        .tbr     (tbr),
        .txd     (txd),
        .rxd     (rxd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [7:0]  tx;
        logic [15:0] div;
        logic [7:0]  exp_rx;
        logic [7:0]  exp_stat;
    } lb_vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_range(input string name, input int act, input int lo, input int hi);
        n_tests++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    // All bus tasks start and end on a falling edge.
    task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
        iocs = 1'b1; iorw = 1'b0; ioaddr = a; tb_dat = d; tb_drv = 1'b1;
        @(negedge clk);
        iocs = 1'b0; tb_drv = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
        iocs = 1'b1; iorw = 1'b1; ioaddr = a; tb_drv = 1'b0;
        #1 d = databus;
        @(negedge clk);
        iocs = 1'b0; iorw = 1'b0;
    endtask

    task automatic set_div(input logic [15:0] d);
        bus_write(2'b10, d[7:0]);
        bus_write(2'b11, d[15:8]);
    endtask

    task automatic wait_tbr(input int bound, output bit ok);
        int n = 0;
        while (tbr !== 1'b1 && n < bound) begin @(negedge clk); n++; end
        ok = (tbr === 1'b1);
    endtask

    task automatic wait_rda(input int bound, output bit ok);
        int n = 0;
        while (rda !== 1'b1 && n < bound) begin @(negedge clk); n++; end
        ok = (rda === 1'b1);
    endtask

    // Bench-side UART receiver: samples txd at mid-bit points derived from the frame start.
    task automatic tx_sample(input int d, output logic [7:0] b, output logic st, output logic sp, output bit ok);
        int p = d + 1;
        int n = 0;
        while (txd !== 1'b0 && n < 64) begin @(negedge clk); n++; end
        ok = (txd === 1'b0);
        repeat (8 * p) @(negedge clk);
        st = txd;
        for (int k = 0; k < 8; k++) begin
            repeat (16 * p) @(negedge clk);
            b[k] = txd;
        end
        repeat (16 * p) @(negedge clk);
        sp = txd;
    endtask

    // Bench-side UART transmitter on rxd; a bad stop bit is held low only long enough to cover mid-bit.
    task automatic send_rx(input logic [7:0] b, input bit stop_ok, input int d);
        int bl = 16 * (d + 1);
        tb_rxd = 1'b0;
        repeat (bl) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            tb_rxd = b[i];
            repeat (bl) @(negedge clk);
        end
        if (stop_ok) begin
            tb_rxd = 1'b1;
            repeat (bl) @(negedge clk);
        end else begin
            tb_rxd = 1'b0;
            repeat (10 * (d + 1)) @(negedge clk);
            tb_rxd = 1'b1;
            repeat (bl) @(negedge clk);
        end
    endtask

    initial begin
        lb_vec_t     lb_tab [4];
        logic [7:0]  rd;
        logic [7:0]  b;
        logic        st, sp;
        bit          ok;
        int          len;
        int          lowcnt;
        logic [7:0]  frame_byte;
        logic [15:0] d;
        logic [7:0]  exp_q [$];
        logic [7:0]  exp_b;

        lb_tab[0] = '{tx: 8'h3C, div: 16'd4, exp_rx: 8'h3C, exp_stat: 8'h03};
        lb_tab[1] = '{tx: 8'h00, div: 16'd1, exp_rx: 8'h00, exp_stat: 8'h03};
        lb_tab[2] = '{tx: 8'hFF, div: 16'd2, exp_rx: 8'hFF, exp_stat: 8'h03};
        lb_tab[3] = '{tx: 8'h81, div: 16'd0, exp_rx: 8'h81, exp_stat: 8'h03};

        n_tests = 0; n_fail = 0;
        rst = 1'b1; iocs = 1'b0; iorw = 1'b0; ioaddr = 2'b00;
        tb_drv = 1'b0; tb_dat = 8'h00; loop = 1'b0; tb_rxd = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("reset_txd", txd, 1'b1);
        chk("reset_tbr", tbr, 1'b1);
        chk("reset_rda", rda, 1'b0);
        bus_read(2'b01, rd);
        chk("reset_status", rd, 8'h02);
        bus_read(2'b00, rd);
        chk("reset_rxbuf", rd, 8'h00);
        iocs = 1'b1; iorw = 1'b0; ioaddr = 2'b01; tb_dat = 8'h00; tb_drv = 1'b1;
        #1 chk("bus_float_on_write", databus, 8'h00);
        @(negedge clk);
        iocs = 1'b0; tb_drv = 1'b0;

        // TX frame 8'hA5 at divisor 4: tick period 5, bit 80 cycles
        set_div(16'd4);
        frame_byte = 8'hA5;
        bus_write(2'b00, frame_byte);
        chk("tx_tbr_fall", tbr, 1'b0);
        chk("tx_start_low", txd, 1'b0);
        len = 0;
        while (txd == 1'b0 && len < 200) begin @(negedge clk); len++; end
        chk_range("tx_first_bit_len", len, 76, 85);
        len = 0;
        while (txd == 1'b1 && len < 200) begin @(negedge clk); len++; end
        chk("tx_bit0_len", len, 80);
        for (int k = 1; k < 8; k++) begin
            repeat ((k == 1) ? 40 : 80) @(negedge clk);
            chk($sformatf("tx_a5_bit%0d", k), txd, frame_byte[k]);
        end
        repeat (80) @(negedge clk);
        chk("tx_a5_stop", txd, 1'b1);
        len = 0;
        while (tbr == 1'b0 && len < 200) begin @(negedge clk); len++; end
        chk("tx_tbr_rise_after_stop", len, 40);

        // Loopback vectors
        loop = 1'b1;
        foreach (lb_tab[i]) begin
            set_div(lb_tab[i].div);
            bus_write(2'b00, lb_tab[i].tx);
            wait_tbr(200 * (int'(lb_tab[i].div) + 1) + 50, ok);
            chk($sformatf("lb%0d_tbr_timeout", i), ok, 1'b1);
            bus_read(2'b01, rd);
            chk($sformatf("lb%0d_status", i), rd, lb_tab[i].exp_stat);
            bus_read(2'b00, rd);
            chk($sformatf("lb%0d_rxdata", i), rd, lb_tab[i].exp_rx);
            chk($sformatf("lb%0d_rda_clear", i), rda, 1'b0);
        end

        // Ignored write while busy
        set_div(16'd1);
        bus_write(2'b00, 8'h11);
        bus_write(2'b00, 8'h22);
        chk("ign_tbr_busy", tbr, 1'b0);
        tx_sample(1, b, st, sp, ok);
        chk("ign_frame_seen", ok, 1'b1);
        chk("ign_byte", b, 8'h11);
        wait_tbr(400, ok);
        chk("ign_tbr_timeout", ok, 1'b1);
        lowcnt = 0;
        repeat (700) begin @(negedge clk); if (txd == 1'b0) lowcnt++; end
        chk("ign_no_second_frame", lowcnt, 0);
        bus_read(2'b00, rd);
        chk("ign_rx_byte", rd, 8'h11);
        loop = 1'b0;

        // Glitch rejection: 3-tick low pulse at tick period 2
        tb_rxd = 1'b0;
        repeat (6) @(negedge clk);
        tb_rxd = 1'b1;
        repeat (400) @(negedge clk);
        chk("glitch_no_rda", rda, 1'b0);

        // Overrun
        send_rx(8'h01, 1'b1, 1);
        send_rx(8'h02, 1'b1, 1);
        chk("ovr_rda", rda, 1'b1);
        bus_read(2'b01, rd);
        chk("ovr_status", rd, 8'h03);
        bus_read(2'b00, rd);
        chk("ovr_data", rd, 8'h02);
        chk("ovr_rda_clear", rda, 1'b0);

        // Frame error
        send_rx(8'h55, 1'b0, 1);
        repeat (100) @(negedge clk);
`ifdef SPART_FRAME_ERR_EN
        chk("ferr_rda", rda, 1'b0);
        bus_read(2'b01, rd);
        chk("ferr_status1", rd, 8'h06);
        bus_read(2'b01, rd);
        chk("ferr_status2", rd, 8'h02);
`else
        chk("noferr_rda", rda, 1'b1);
        bus_read(2'b01, rd);
        chk("noferr_status", rd, 8'h03);
        bus_read(2'b00, rd);
        chk("noferr_data", rd, 8'h55);
`endif

        // Randomized TX and RX against bench UART models
        for (int i = 0; i < 6; i++) begin
            d = 16'($urandom_range(0, 3));
            set_div(d);
            frame_byte = 8'($urandom);
            bus_write(2'b00, frame_byte);
            tx_sample(int'(d), b, st, sp, ok);
            chk($sformatf("rnd%0d_tx_seen", i), ok, 1'b1);
            chk($sformatf("rnd%0d_tx_start", i), st, 1'b0);
            chk($sformatf("rnd%0d_tx_byte", i), b, frame_byte);
            chk($sformatf("rnd%0d_tx_stop", i), sp, 1'b1);
            wait_tbr(20 * (int'(d) + 1) + 20, ok);
            chk($sformatf("rnd%0d_tbr", i), ok, 1'b1);
            exp_b = 8'($urandom);
            exp_q.push_back(exp_b);
            send_rx(exp_b, 1'b1, int'(d));
            wait_rda(50, ok);
            chk($sformatf("rnd%0d_rda", i), ok, 1'b1);
            bus_read(2'b00, rd);
            exp_b = exp_q.pop_front();
            chk($sformatf("rnd%0d_rx_byte", i), rd, exp_b);
        end

        // Reset mid-frame
        set_div(16'd4);
        bus_write(2'b00, 8'h0F);
        repeat (150) @(negedge clk);
        chk("midrst_busy", tbr, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_txd", txd, 1'b1);
        chk("midrst_tbr", tbr, 1'b1);
        bus_read(2'b01, rd);
        chk("midrst_status", rd, 8'h02);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
